// File: rtl/cache_memory_buffer.sv
// rtl/cache_memory_buffer.sv - in-order load/store request buffer between data cache and memory controller
// Optional zero-latency bypass of an empty FIFO: define CACHE_BUFFER_BYPASS_EN.
module cache_memory_buffer #(
  parameter int DEPTH           = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        invalidate_i,
  input  logic        load_request_i,
  input  logic [31:0] load_address_i,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  input  logic        store_request_i,
  input  logic [31:0] store_address_i,
  input  logic [31:0] store_data_i,
  output logic        full_o,
  output logic        overflow_o,
  output logic        mem_request_o,
  output logic        mem_write_o,
  output logic [31:0] mem_address_o,
  output logic [31:0] mem_data_o,
  input  logic        mem_ready_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_data_i
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int OUT_W    = $clog2(MAX_OUTSTANDING) + 1;
  localparam int DISC_MAX = DEPTH + MAX_OUTSTANDING;
  localparam int DISC_W   = $clog2(DISC_MAX + 1);
  localparam int SUM_W    = $clog2(2 * DISC_MAX + 1);

  logic              fifo_write_q [DEPTH];
  logic [31:0]       fifo_addr_q  [DEPTH];
  logic [31:0]       fifo_data_q  [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  qload_q, qload_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [DISC_W-1:0] disc_q, disc_d;
  logic              full_q, full_d;
  logic              ovf_q, ovf_d;

  logic              bypass_active;
  logic              head_write;
  logic [31:0]       head_addr;
  logic [31:0]       head_data;
  logic              mem_req;
  logic              issue;
  logic              pop;
  logic [1:0]        n_req;
  logic [CNT_W-1:0]  n_free;
  logic              push0;
  logic              push1;
  logic              push0_write;
  logic [31:0]       push0_addr;
  logic [31:0]       push0_data;
  logic              resp_ok;
  logic              disc_dec;
  logic [SUM_W-1:0]  disc_sum;

  // Select the request presented to memory and decide whether it may issue
  always_comb begin
    bypass_active = 1'b0;
`ifdef CACHE_BUFFER_BYPASS_EN
    bypass_active = rst_n_i && (count_q == '0) && (store_request_i ^ load_request_i);
`endif
    if (bypass_active) begin
      head_write = store_request_i;
      head_addr  = store_request_i ? store_address_i : load_address_i;
      head_data  = store_request_i ? store_data_i : 32'h0;
    end else begin
      head_write = fifo_write_q[rd_ptr_q];
      head_addr  = fifo_addr_q[rd_ptr_q];
      head_data  = fifo_data_q[rd_ptr_q];
    end
    // A load at the head waits while the outstanding window is full; stores never wait
    mem_req = ((count_q != '0) || bypass_active) &&
              !(!head_write && (out_q == OUT_W'(MAX_OUTSTANDING)));
    issue   = mem_req && mem_ready_i;
    pop     = issue && !bypass_active;
  end

  // Enqueue up to two requests (store before load), dropping the newest on lack of space
  always_comb begin
    n_req = {1'b0, store_request_i} + {1'b0, load_request_i};
    if (issue && bypass_active) begin
      n_req = 2'd0;
    end
    n_free      = CNT_W'(DEPTH) - count_q;
    push0       = (n_req != 2'd0) && (n_free != '0);
    push1       = (n_req == 2'd2) && (n_free >= CNT_W'(2));
    push0_write = store_request_i;
    push0_addr  = store_request_i ? store_address_i : load_address_i;
    push0_data  = store_request_i ? store_data_i : 32'h0;
    ovf_d       = ((n_req != 2'd0) && !push0) || ((n_req == 2'd2) && !push1);
    wr_ptr_d    = wr_ptr_q + PTR_W'(push0) + PTR_W'(push1);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    count_d     = count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
    full_d      = count_d > CNT_W'(DEPTH - 2);
    qload_d     = qload_q + CNT_W'(push0 && !push0_write) + CNT_W'(push1)
                  - CNT_W'(pop && !head_write);
  end

  // Track outstanding loads, forward or discard responses, and grow the discard count on invalidate
  always_comb begin
    resp_ok      = mem_valid_i && (out_q != '0);
    disc_dec     = resp_ok && (disc_q != '0);
    out_d        = out_q + OUT_W'(issue && !head_write) - OUT_W'(resp_ok);
    load_valid_o = resp_ok && (disc_q == '0);
    load_data_o  = load_valid_o ? mem_data_i : 32'h0;
    disc_sum     = SUM_W'(disc_q) - SUM_W'(disc_dec);
    if (invalidate_i) begin
      disc_sum = disc_sum + SUM_W'(out_d) + SUM_W'(qload_d);
    end
    disc_d = (disc_sum > SUM_W'(DISC_MAX)) ? DISC_W'(DISC_MAX) : disc_sum[DISC_W-1:0];
  end

  // Control state registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      qload_q  <= '0;
      out_q    <= '0;
      disc_q   <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      qload_q  <= qload_d;
      out_q    <= out_d;
      disc_q   <= disc_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; contents are only observed through the head when count is nonzero
  always_ff @(posedge clk_i) begin
    if (push0) begin
      fifo_write_q[wr_ptr_q] <= push0_write;
      fifo_addr_q[wr_ptr_q]  <= push0_addr;
      fifo_data_q[wr_ptr_q]  <= push0_data;
    end
    if (push1) begin
      fifo_write_q[wr_ptr_q + PTR_W'(1)] <= 1'b0;
      fifo_addr_q[wr_ptr_q + PTR_W'(1)]  <= load_address_i;
      fifo_data_q[wr_ptr_q + PTR_W'(1)]  <= 32'h0;
    end
  end

  assign mem_request_o = mem_req;
  assign mem_write_o   = mem_req && head_write;
  assign mem_address_o = mem_req ? head_addr : 32'h0;
  assign mem_data_o    = mem_req ? head_data : 32'h0;
  assign full_o        = full_q;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_cache_memory_buffer.sv
// tb/tb_cache_memory_buffer.sv - randomized and directed bench for cache_memory_buffer
module tb_cache_memory_buffer;

  localparam int DEPTH = 8;
  localparam int MAXO  = 4;
  localparam int DMAX  = DEPTH + MAXO;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        invalidate_i;
  logic        load_request_i;
  logic [31:0] load_address_i;
  logic [31:0] load_data_o;
  logic        load_valid_o;
  logic        store_request_i;
  logic [31:0] store_address_i;
  logic [31:0] store_data_i;
  logic        full_o;
  logic        overflow_o;
  logic        mem_request_o;
  logic        mem_write_o;
  logic [31:0] mem_address_o;
  logic [31:0] mem_data_o;
  logic        mem_ready_i;
  logic        mem_valid_i;
  logic [31:0] mem_data_i;

  always #5 clk_i = ~clk_i;

  cache_memory_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .invalidate_i    (invalidate_i),
    .load_request_i  (load_request_i),
    .load_address_i  (load_address_i),
    .load_data_o     (load_data_o),
    .load_valid_o    (load_valid_o),
    .store_request_i (store_request_i),
    .store_address_i (store_address_i),
    .store_data_i    (store_data_i),
    .full_o          (full_o),
    .overflow_o      (overflow_o),
    .mem_request_o   (mem_request_o),
    .mem_write_o     (mem_write_o),
    .mem_address_o   (mem_address_o),
    .mem_data_o      (mem_data_o),
    .mem_ready_i     (mem_ready_i),
    .mem_valid_i     (mem_valid_i),
    .mem_data_i      (mem_data_i)
  );

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } req_t;

  // Reference model: pending requests in order, plus plain integer counts
  req_t mq[$];
  int   m_out;
  int   m_disc;
  bit   m_full;
  bit   m_ovf;

  int n_checks    = 0;
  int n_pass      = 0;
  int valid_seen  = 0;
  int beef_seen   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int model_qloads();
    int n = 0;
    foreach (mq[i]) if (!mq[i].w) n++;
    return n;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_out  = 0;
    m_disc = 0;
    m_full = 0;
    m_ovf  = 0;
  endtask

  // Check all outputs for the inputs currently driven, advance the model, move past the next edge
  task automatic step();
    req_t head;
    req_t inc_s;
    req_t inc_l;
    bit   byp;
    bit   exp_req;
    bit   issue;
    bit   resp_ok;
    bit   exp_v;
    int   free0;
    int   dropped;
    head  = '0;
    byp   = 0;
    inc_s = {1'b1, store_address_i, store_data_i};
    inc_l = {1'b0, load_address_i, 32'h0};
    #1;
    free0 = DEPTH - mq.size();
`ifdef CACHE_BUFFER_BYPASS_EN
    byp = (mq.size() == 0) && (store_request_i ^ load_request_i);
`endif
    if (byp) head = store_request_i ? inc_s : inc_l;
    else if (mq.size() > 0) head = mq[0];
    exp_req = (mq.size() > 0 || byp) && !(!head.w && m_out == MAXO);
    check_eq("mem_request", {31'h0, mem_request_o}, {31'h0, exp_req});
    check_eq("mem_address", mem_address_o, exp_req ? head.a : 32'h0);
    if (exp_req) check_eq("mem_write", {31'h0, mem_write_o}, {31'h0, head.w});
    if (!exp_req || head.w) check_eq("mem_data", mem_data_o, exp_req ? head.d : 32'h0);
    check_eq("full", {31'h0, full_o}, {31'h0, m_full});
    check_eq("overflow", {31'h0, overflow_o}, {31'h0, m_ovf});
    resp_ok = mem_valid_i && (m_out > 0);
    exp_v   = resp_ok && (m_disc == 0);
    check_eq("load_valid", {31'h0, load_valid_o}, {31'h0, exp_v});
    check_eq("load_data", load_data_o, exp_v ? mem_data_i : 32'h0);
    if (load_valid_o) begin
      valid_seen++;
      if (load_data_o == 32'hDEAD_BEEF) beef_seen++;
    end
    issue = exp_req && mem_ready_i;
    if (issue && !byp) void'(mq.pop_front());
    if (issue && !head.w) m_out++;
    dropped = 0;
    if (!(issue && byp)) begin
      if (store_request_i) begin
        if (free0 > 0) begin mq.push_back(inc_s); free0--; end
        else dropped++;
      end
      if (load_request_i) begin
        if (free0 > 0) begin mq.push_back(inc_l); free0--; end
        else dropped++;
      end
    end
    m_ovf = dropped > 0;
    if (resp_ok) begin
      m_out--;
      if (m_disc > 0) m_disc--;
    end
    if (invalidate_i) begin
      m_disc = m_disc + m_out + model_qloads();
      if (m_disc > DMAX) m_disc = DMAX;
    end
    m_full = (DEPTH - mq.size()) < 2;
    @(posedge clk_i);
    #1;
  endtask

  task automatic cyc(input logic st, input logic [31:0] sa, input logic [31:0] sd,
                     input logic ld, input logic [31:0] la, input logic rdy,
                     input logic vld, input logic [31:0] vd, input logic inv);
    store_request_i = st;
    store_address_i = sa;
    store_data_i    = sd;
    load_request_i  = ld;
    load_address_i  = la;
    mem_ready_i     = rdy;
    mem_valid_i     = vld;
    mem_data_i      = vd;
    invalidate_i    = inv;
    step();
  endtask

  task automatic idle(input logic rdy);
    cyc(0, 0, 0, 0, 0, rdy, 0, 0, 0);
  endtask

  task automatic respond(input logic [31:0] d);
    cyc(0, 0, 0, 0, 0, 1, 1, d, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_req"}, {31'h0, mem_request_o}, 32'h0);
    check_eq({tag, "_write"}, {31'h0, mem_write_o}, 32'h0);
    check_eq({tag, "_addr"}, mem_address_o, 32'h0);
    check_eq({tag, "_mdata"}, mem_data_o, 32'h0);
    check_eq({tag, "_full"}, {31'h0, full_o}, 32'h0);
    check_eq({tag, "_ovf"}, {31'h0, overflow_o}, 32'h0);
    check_eq({tag, "_lvalid"}, {31'h0, load_valid_o}, 32'h0);
    check_eq({tag, "_ldata"}, load_data_o, 32'h0);
  endtask

  int v0;

  initial begin
    rst_n_i         = 1'b0;
    invalidate_i    = 1'b0;
    load_request_i  = 1'b0;
    load_address_i  = 32'h0;
    store_request_i = 1'b0;
    store_address_i = 32'h0;
    store_data_i    = 32'h0;
    mem_ready_i     = 1'b0;
    mem_valid_i     = 1'b0;
    mem_data_i      = 32'h0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    rst_n_i = 1'b1;
    idle(1);

    // Single load with response three cycles after issue
    beef_seen = 0;
    cyc(0, 0, 0, 1, 32'h0000_1004, 1, 0, 0, 0);
    idle(1);
    idle(1);
    idle(1);
    respond(32'hDEAD_BEEF);
    idle(1);
    check_eq("t1_beef_pulses", beef_seen, 1);

    // Store and load in the same cycle: store reaches memory first
    cyc(1, 32'h10, 32'h1234_5678, 1, 32'h20, 1, 0, 0, 0);
    idle(1);
    idle(1);
    respond(32'h0BAD_F00D);
    idle(1);

    // Fill with memory stalled: full after 7, drop on the 9th push
    for (int i = 0; i < 9; i++) begin
      cyc(1, 32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i), 0, 0, 0, 0, 0, 0);
      if (i == 5) check_eq("t3_full_after6", {31'h0, full_o}, 32'h0);
      if (i == 6) check_eq("t3_full_after7", {31'h0, full_o}, 32'h1);
      if (i == 7) check_eq("t3_no_ovf_8th", {31'h0, overflow_o}, 32'h0);
      if (i == 8) check_eq("t3_ovf_9th", {31'h0, overflow_o}, 32'h1);
    end
    idle(0);
    check_eq("t3_ovf_one_cycle", {31'h0, overflow_o}, 32'h0);
    check_eq("t3_still_full", {31'h0, full_o}, 32'h1);
    repeat (10) idle(1);

    // Outstanding-load limit
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 32'h200 + 32'(i * 4), 1, 0, 0, 0);
    repeat (3) idle(1);
    check_eq("t4_fifth_held", {31'h0, mem_request_o}, 32'h0);
    respond(32'h5555_0001);
    check_eq("t4_fifth_issues", {31'h0, mem_request_o}, 32'h1);
    idle(1);
    for (int i = 0; i < 4; i++) respond(32'h5555_0010 + 32'(i));
    idle(1);

    // Invalidate with two in flight and one queued
    cyc(0, 0, 0, 1, 32'h300, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h304, 1, 0, 0, 0);
    idle(1);
    cyc(0, 0, 0, 1, 32'h308, 0, 0, 0, 0);
    idle(0);
    v0 = valid_seen;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    for (int i = 0; i < 3; i++) respond(32'h7777_0000 + 32'(i));
    check_eq("t5_dropped", valid_seen - v0, 0);
    cyc(0, 0, 0, 1, 32'h30C, 1, 0, 0, 0);
    idle(1);
    respond(32'h7777_00FF);
    check_eq("t5_new_load", valid_seen - v0, 1);

    // Reset with loads in flight, then stray responses
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 32'h400 + 32'(i * 4), 1, 0, 0, 0);
    idle(1);
    idle(1);
    rst_n_i         = 1'b0;
    load_request_i  = 1'b0;
    store_request_i = 1'b0;
    invalidate_i    = 1'b0;
    mem_ready_i     = 1'b1;
    mem_valid_i     = 1'b1;
    mem_data_i      = 32'h9999_9999;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    v0 = valid_seen;
    for (int i = 0; i < 3; i++) respond(32'h8888_0000 + 32'(i));
    check_eq("t6_stray_ignored", valid_seen - v0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) == 0, $urandom() & 32'hFFFF_FFFC, $urandom(),
          $urandom_range(0, 2) == 0, $urandom() & 32'hFFFF_FFFC,
          $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom(),
          $urandom_range(0, 31) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_memory_buffer.md
Name: cache_memory_buffer

Overview:
- Sits between the data cache load/store controllers and the memory controller.
- Queues word load requests (allocation) and word store requests (write-back) in one in-order FIFO and issues them to memory with a request/ready handshake.
- Returns load data in order and can discard in-flight loads on invalidation.
- Its full flag drives the controllers' stall input.

Parameters:
- DEPTH, 8, request FIFO entries; power of two, at least 4.
- MAX_OUTSTANDING, 4, maximum loads issued to memory but not yet answered; power of two.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- invalidate_i  in  1  discard responses of every queued and in-flight load
- load_request_i  in  1  enqueue a load
- load_address_i  in  32  word-aligned load address
- load_data_o  out  32  load response data
- load_valid_o  out  1  load response strobe
- store_request_i  in  1  enqueue a store
- store_address_i  in  32  word-aligned store address
- store_data_i  in  32  store data
- full_o  out  1  fewer than 2 free FIFO entries; upstream stall
- overflow_o  out  1  one-cycle pulse: a request was dropped
- mem_request_o  out  1  memory request valid
- mem_write_o  out  1  1 = store, 0 = load
- mem_address_o  out  32  memory address
- mem_data_o  out  32  store data
- mem_ready_i  in  1  memory accepts the request this cycle
- mem_valid_i  in  1  load response valid
- mem_data_i  in  32  load response data

Behaviour:
- Reset: all outputs 0; FIFO empty; outstanding, queued-load and discard counters 0. Reset mid-operation abandons all entries; memory responses arriving after reset are ignored because the counters are 0.
- FIFO entry: {write, address, data}.
- Enqueue:
  - Up to two pushes per cycle.
  - When store_request_i and load_request_i are both high, the store is written first, then the load.
  - Requests that do not fit in the free entries are dropped, newest first, and overflow_o pulses the next cycle.
  - full_o is registered: high when free entries < 2 after this cycle's pushes and pops.
- Issue:
  - Head entry is visible on mem_* the cycle after enqueue.
  - mem_request_o = FIFO not empty AND NOT (head is a load AND outstanding == MAX_OUTSTANDING).
  - Pop when mem_request_o & mem_ready_i.
  - An issued load increments the outstanding counter.
  - mem_address_o and mem_data_o are 0 when mem_request_o is low.
- Response:
  - On mem_valid_i, outstanding decrements.
  - If discard == 0: load_data_o = mem_data_i and load_valid_o = 1 the same cycle (combinational).
  - Otherwise: discard decrements, load_valid_o = 0, load_data_o = 0.
  - mem_valid_i with outstanding == 0 is ignored.
- Invalidate:
  - discard <= discard + outstanding + queued_loads, using next-cycle values; includes a load pushed or issued in the same cycle and excludes a response consumed that cycle.
  - Queued loads are still issued; their responses are dropped.
  - Stores are never dropped.
  - The discard counter saturates at DEPTH + MAX_OUTSTANDING; size it accordingly.
- Simultaneous issue, response and enqueue in one cycle: every counter applies all increments and decrements together.
- Pointers and counters wrap modulo their power-of-two size.
- No combinational path from the memory inputs to mem_request_o, except mem_ready_i gating the pop.

Optional Feature:
- Macro: CACHE_BUFFER_BYPASS_EN.
- With the macro defined:
  - When the FIFO is empty and only one request arrives, it is presented on mem_* in the same cycle (zero latency), subject to the outstanding-load limit.
  - If mem_ready_i is high, it is not written to the FIFO; otherwise it is enqueued normally.
- Without the macro: minimum issue latency is one cycle and every request passes through the FIFO.

Test Plan:
- Reset, then one load to 0x0000_1004 with mem_ready_i = 1 and a response 0xDEAD_BEEF three cycles later -> mem_request_o high 1 cycle after enqueue (0 with bypass); load_valid_o pulses once with 0xDEAD_BEEF.
- Store 0x10 with data 0x1234_5678 and load 0x20 in the same cycle -> memory sees the store first (mem_write_o = 1), then the load; order is preserved.
- mem_ready_i held 0 while one request is pushed per cycle -> full_o rises after 7 entries; a push into a full FIFO sets overflow_o for one cycle and the entry count stays 8.
- Five loads with mem_ready_i = 1 and no responses -> 4 issued, 5th held (mem_request_o = 0); one response frees a slot and the 5th issues the next cycle.
- 2 loads outstanding plus 1 queued, then invalidate_i for 1 cycle -> all 3 responses are dropped (load_valid_o stays 0); a new load afterwards returns normally.
- Assert rst_n_i low while 3 loads are outstanding -> outputs go to 0 immediately; stray mem_valid_i pulses after reset produce no load_valid_o.
